// File: rtl/bp_be_pkg.sv
// Shared types for the FP backend writeback path: register value layout,
// exception flag layout and the FMA writeback buffer entry.
package bp_be_pkg;

  localparam int dpath_width_gp    = 66;
  localparam int reg_addr_width_gp = 5;
  localparam int fflags_width_gp   = 5;

  // One FP register value: precision tag plus 65-bit recoded double.
  typedef struct packed {
    logic        sp_not_dp;
    logic [64:0] rec;
  } bp_be_fp_reg_s;

  // RISC-V accrued exception flags, fcsr bit order.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } rv64_fflags_s;

  // One buffered FMA result waiting for the register-file write port.
  typedef struct packed {
    logic [reg_addr_width_gp-1:0] rd;
    bp_be_fp_reg_s                data;
    rv64_fflags_s                 fflags;
  } bp_be_fma_wb_entry_s;

endpackage

// File: rtl/bp_be_fma_wb_fifo.sv
// Small circular FIFO of FMA writeback entries. Pointers are log2(els_p)
// bits and wrap naturally; a separate occupancy counter resolves full/empty.
// Enqueue and dequeue together are legal at any occupancy, including full.
module bp_be_fma_wb_fifo
  import bp_be_pkg::*;
#(
  parameter  int els_p     = 4,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enq_i,
  input  logic                  deq_i,
  input  bp_be_fma_wb_entry_s   data_i,
  output bp_be_fma_wb_entry_s   data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [lg_els_lp:0]    count_o
);

  localparam logic [lg_els_lp-1:0] ptr_one_lp  = 1;
  localparam logic [lg_els_lp:0]   cnt_one_lp  = 1;
  localparam logic [lg_els_lp:0]   els_cnt_lp  = (lg_els_lp+1)'(els_p);

  bp_be_fma_wb_entry_s mem [els_p];

  logic [lg_els_lp-1:0] rptr;
  logic [lg_els_lp-1:0] wptr;
  logic [lg_els_lp:0]   count;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (enq_i) wptr <= wptr + ptr_one_lp;
      if (deq_i) rptr <= rptr + ptr_one_lp;
      case ({enq_i, deq_i})
        2'b10:   count <= count + cnt_one_lp;
        2'b01:   count <= count - cnt_one_lp;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only and needs no reset.
  always_ff @(posedge clk_i) begin
    if (enq_i) mem[wptr] <= data_i;
  end

  assign data_o  = mem[rptr];
  assign count_o = count;
  assign empty_o = (count == '0);
  assign full_o  = (count == els_cnt_lp);

  a_deq_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    deq_i |-> !empty_o);

endmodule

// File: rtl/bp_be_fma_wb_buffer.sv
// FMA writeback buffer. Captures every result of the non-stallable FMA pipe,
// drains it to the shared FP register-file write port (load pipe has
// priority, signalled by wb_yumi_i), hands issue credits to the dispatcher so
// the pipe can never overrun the buffer, and accumulates sticky fflags at
// writeback time.
// Build option: define BP_BE_FMA_WB_BYPASS_EN to present an arriving result
// on wb_* in the same cycle when the FIFO is empty.
module bp_be_fma_wb_buffer
  import bp_be_pkg::*;
#(
  parameter int dpath_width_p    = dpath_width_gp,
  parameter int reg_addr_width_p = reg_addr_width_gp,
  parameter int els_p            = 4,
  parameter int fma_latency_p    = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        fma_issue_i,
  output logic                        issue_ready_o,
  input  logic                        fma_v_i,
  input  logic [dpath_width_p-1:0]    fma_data_i,
  input  logic [fflags_width_gp-1:0]  fma_fflags_i,
  input  logic [reg_addr_width_p-1:0] fma_rd_i,
  output logic                        wb_v_o,
  output logic [reg_addr_width_p-1:0] wb_addr_o,
  output logic [dpath_width_p-1:0]    wb_data_o,
  input  logic                        wb_yumi_i,
  output logic [fflags_width_gp-1:0]  fflags_o,
  input  logic                        fflags_clear_i,
  output logic                        empty_o
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam logic [lg_els_lp:0]   infl_one_lp = 1;
  localparam logic [lg_els_lp+1:0] els_lp      = (lg_els_lp+2)'(els_p);

  bp_be_fma_wb_entry_s fma_entry;
  bp_be_fma_wb_entry_s fifo_head;
  bp_be_fma_wb_entry_s wb_entry;
  logic                fifo_enq;
  logic                fifo_deq;
  logic                fifo_full;
  logic                fifo_empty;
  logic [lg_els_lp:0]  fifo_count;
  logic [lg_els_lp:0]  inflight;
  logic [lg_els_lp+1:0] used;

  assign fma_entry = '{rd: fma_rd_i, data: fma_data_i, fflags: fma_fflags_i};

`ifdef BP_BE_FMA_WB_BYPASS_EN
  // An arriving result goes straight to the port when nothing is queued;
  // it is only stored if the port is not granted this cycle.
  logic bypass_sel;
  assign bypass_sel = fifo_empty & fma_v_i;
  assign wb_v_o     = ~fifo_empty | bypass_sel;
  assign wb_entry   = bypass_sel ? fma_entry : fifo_head;
  assign fifo_enq   = fma_v_i & ~(bypass_sel & wb_yumi_i);
`else
  assign wb_v_o     = ~fifo_empty;
  assign wb_entry   = fifo_head;
  assign fifo_enq   = fma_v_i;
`endif

  assign fifo_deq  = wb_yumi_i & ~fifo_empty;
  assign wb_addr_o = wb_entry.rd;
  assign wb_data_o = wb_entry.data;

  bp_be_fma_wb_fifo #(.els_p(els_p)) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enq_i   (fifo_enq),
    .deq_i   (fifo_deq),
    .data_i  (fma_entry),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Results issued but not yet returned by the pipe.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      inflight <= '0;
    end else begin
      case ({fma_issue_i, fma_v_i})
        2'b10:   inflight <= inflight + infl_one_lp;
        2'b01:   inflight <= inflight - infl_one_lp;
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky flags collected as results leave; a CSR clear wins and drops them.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fflags_o <= '0;
    end else if (fflags_clear_i) begin
      fflags_o <= '0;
    end else if (wb_yumi_i) begin
      fflags_o <= fflags_o | wb_entry.fflags;
    end
  end

  // Every slot is either occupied or promised to an op still in the pipe.
  assign used          = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue_ready_o = (used < els_lp);
  assign empty_o       = fifo_empty & (inflight == '0);

  a_overrun: assert property (@(posedge clk_i) disable iff (reset_i)
    (fma_v_i && fifo_full) |-> wb_yumi_i);
  a_issue_no_credit: assert property (@(posedge clk_i) disable iff (reset_i)
    fma_issue_i |-> issue_ready_o);
  a_yumi_no_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    wb_yumi_i |-> wb_v_o);
  a_inflight_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    (fma_v_i && !fma_issue_i) |-> (inflight != '0));
  a_inflight_latency: assert property (@(posedge clk_i) disable iff (reset_i)
    int'(inflight) <= fma_latency_p);

endmodule

// File: tb/tb_bp_be_fma_wb_buffer.sv
module tb_bp_be_fma_wb_buffer;

  typedef struct {
    logic [4:0]  rd;
    logic [65:0] data;
    logic [4:0]  ff;
  } ent_t;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [65:0] data;
    logic [4:0]  ff;
  } pe_t;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        fma_issue_i = 1'b0;
  logic        issue_ready_o;
  logic        fma_v_i = 1'b0;
  logic [65:0] fma_data_i = '0;
  logic [4:0]  fma_fflags_i = '0;
  logic [4:0]  fma_rd_i = '0;
  logic        wb_v_o;
  logic [4:0]  wb_addr_o;
  logic [65:0] wb_data_o;
  logic        wb_yumi_i = 1'b0;
  logic [4:0]  fflags_o;
  logic        fflags_clear_i = 1'b0;
  logic        empty_o;

  int checks = 0;
  int errors = 0;

  ent_t       m_q[$];
  int         m_infl = 0;
  logic [4:0] m_ff = '0;
  pe_t        pipe[$];
  logic [4:0] wlog[$];

  always #5 clk_i = ~clk_i;

  bp_be_fma_wb_buffer dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .fma_issue_i    (fma_issue_i),
    .issue_ready_o  (issue_ready_o),
    .fma_v_i        (fma_v_i),
    .fma_data_i     (fma_data_i),
    .fma_fflags_i   (fma_fflags_i),
    .fma_rd_i       (fma_rd_i),
    .wb_v_o         (wb_v_o),
    .wb_addr_o      (wb_addr_o),
    .wb_data_o      (wb_data_o),
    .wb_yumi_i      (wb_yumi_i),
    .fflags_o       (fflags_o),
    .fflags_clear_i (fflags_clear_i),
    .empty_o        (empty_o)
  );

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [65:0] rand66();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[65:0];
  endfunction

  // Expected outputs from the queue model: the head of the queue is on the
  // port; with bypass an arriving result is on the port when nothing is queued.
  function automatic logic exp_wb_v();
    if (m_q.size() != 0) return 1'b1;
`ifdef BP_BE_FMA_WB_BYPASS_EN
    if (fma_v_i) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic ent_t exp_head();
    ent_t e;
    if (m_q.size() != 0) e = m_q[0];
    else e = '{fma_rd_i, fma_data_i, fma_fflags_i};
    return e;
  endfunction

  function automatic logic exp_ready();
    return (m_q.size() + m_infl) < 4;
  endfunction

  // Reference model: results queue, count of ops in the pipe, sticky flags.
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      m_q.delete();
      m_infl = 0;
      m_ff = '0;
    end else begin
      logic       byp;
      logic [4:0] dq;
      ent_t       e;
      byp = 1'b0;
`ifdef BP_BE_FMA_WB_BYPASS_EN
      byp = (m_q.size() == 0) && fma_v_i;
`endif
      dq = '0;
      if (wb_yumi_i) begin
        if (byp) dq = fma_fflags_i;
        else if (m_q.size() != 0) begin
          e = m_q.pop_front();
          dq = e.ff;
        end
      end
      if (fma_v_i && !(byp && wb_yumi_i))
        m_q.push_back('{fma_rd_i, fma_data_i, fma_fflags_i});
      m_infl = m_infl + int'(fma_issue_i) - int'(fma_v_i);
      if (fflags_clear_i) m_ff = '0;
      else m_ff = m_ff | dq;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      ent_t h;
      h = exp_head();
      chk("wb_v", {65'd0, wb_v_o}, {65'd0, exp_wb_v()});
      if (exp_wb_v()) begin
        chk("wb_addr", {61'd0, wb_addr_o}, {61'd0, h.rd});
        chk("wb_data", wb_data_o, h.data);
      end
      chk("issue_ready", {65'd0, issue_ready_o}, {65'd0, exp_ready()});
      chk("empty", {65'd0, empty_o}, {65'd0, (m_q.size() == 0 && m_infl == 0)});
      chk("fflags", {61'd0, fflags_o}, {61'd0, m_ff});
      if (wb_v_o && wb_yumi_i) wlog.push_back(wb_addr_o);
    end
  end

  task automatic pipe_reset();
    pipe.delete();
    for (int i = 0; i < 5; i++) pipe.push_back('{1'b0, 5'd0, 66'd0, 5'd0});
  endtask

  // Apply one cycle's inputs; the FMA pipe returns each issued op 5 cycles later.
  task automatic set_inputs(input logic iss, input logic [4:0] rd, input logic [65:0] d,
                            input logic [4:0] ff, input logic yumi_req, input logic clr);
    pe_t p;
    p = pipe.pop_front();
    fma_v_i      = p.v;
    fma_rd_i     = p.rd;
    fma_data_i   = p.data;
    fma_fflags_i = p.ff;
    fma_issue_i  = iss && exp_ready();
    pipe.push_back('{fma_issue_i, rd, d, ff});
    wb_yumi_i      = yumi_req && exp_wb_v();
    fflags_clear_i = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic yumi_req);
    set_inputs(1'b0, 5'd0, 66'd0, 5'd0, yumi_req, 1'b0);
    tick();
  endtask

  logic [65:0] dc [1:5];
  logic [65:0] d_single;

  initial begin
    pipe_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    #1;
    chk("rst_wb_v", {65'd0, wb_v_o}, 66'd0);
    chk("rst_ready", {65'd0, issue_ready_o}, 66'd1);
    chk("rst_empty", {65'd0, empty_o}, 66'd1);
    chk("rst_fflags", {61'd0, fflags_o}, 66'd0);

    // Single op: issue at 0, result at 5, written at 6 (registered path).
    d_single = 66'h1_0000_0000_0000_0001;
    for (int c = 0; c < 8; c++) begin
      set_inputs(c == 0, 5'd3, d_single, 5'b00001, 1'b1, 1'b0);
`ifdef BP_BE_FMA_WB_BYPASS_EN
      if (c == 5) begin
        chk("single_byp_v", {65'd0, wb_v_o}, 66'd1);
        chk("single_byp_addr", {61'd0, wb_addr_o}, 66'd3);
        chk("single_byp_data", wb_data_o, d_single);
      end
`else
      if (c == 5) chk("single_v_c5", {65'd0, wb_v_o}, 66'd0);
      if (c == 6) begin
        chk("single_v_c6", {65'd0, wb_v_o}, 66'd1);
        chk("single_addr", {61'd0, wb_addr_o}, 66'd3);
        chk("single_data", wb_data_o, d_single);
      end
`endif
      if (c == 7) begin
        chk("single_fflags", {61'd0, fflags_o}, 66'd1);
        chk("single_empty", {65'd0, empty_o}, 66'd1);
      end
      tick();
    end

    // Credit exhaustion, port contention and in-order drain of rd 1..5.
    for (int i = 1; i <= 5; i++) dc[i] = rand66();
    wlog.delete();
    for (int c = 0; c < 22; c++) begin
      logic [4:0] rd;
      rd = (c < 4) ? 5'(c + 1) : 5'd5;
      set_inputs((c < 4) || (c == 10), rd, dc[rd], 5'($urandom_range(0, 31)),
                 (c == 9) || (c >= 11), 1'b0);
      if (c == 4) chk("credit_exhausted", {65'd0, issue_ready_o}, 66'd0);
      if (c >= 6 && c <= 8) begin
        chk("contend_v", {65'd0, wb_v_o}, 66'd1);
        chk("contend_addr", {61'd0, wb_addr_o}, 66'd1);
        chk("contend_data", wb_data_o, dc[1]);
      end
      if (c == 9) chk("full_not_ready", {65'd0, issue_ready_o}, 66'd0);
      if (c == 10) chk("credit_returned", {65'd0, issue_ready_o}, 66'd1);
      tick();
    end
    chk("order_count", 66'(wlog.size()), 66'd5);
    for (int i = 0; i < 5; i++)
      if (i < wlog.size()) chk("order_rd", {61'd0, wlog[i]}, 66'(i + 1));

    // Clear wins over a same-cycle dequeue.
    for (int c = 0; c < 9; c++) begin
      set_inputs(c < 2, (c == 0) ? 5'd10 : 5'd11, rand66(),
                 (c == 0) ? 5'b00100 : 5'b10000, (c == 6) || (c == 7), c == 0 || c == 7);
      if (c == 7) chk("fflags_before_clear", {61'd0, fflags_o}, 66'b00100);
      if (c == 8) begin
        chk("fflags_cleared", {61'd0, fflags_o}, 66'd0);
        chk("clear_empty", {65'd0, empty_o}, 66'd1);
      end
      tick();
    end

`ifdef BP_BE_FMA_WB_BYPASS_EN
    // Bypass on an empty FIFO with the port granted: nothing is stored.
    for (int c = 0; c < 7; c++) begin
      set_inputs(c == 0, 5'd12, d_single, 5'b00010, c == 5, c == 0);
      if (c == 5) begin
        chk("byp_same_cycle_v", {65'd0, wb_v_o}, 66'd1);
        chk("byp_same_cycle_addr", {61'd0, wb_addr_o}, 66'd12);
      end
      if (c == 6) begin
        chk("byp_not_stored", {65'd0, wb_v_o}, 66'd0);
        chk("byp_empty", {65'd0, empty_o}, 66'd1);
        chk("byp_fflags", {61'd0, fflags_o}, 66'b00010);
      end
      tick();
    end
`endif

    // Randomized traffic under the credit protocol.
    for (int c = 0; c < 1500; c++) begin
      set_inputs($urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), rand66(),
                 5'($urandom_range(0, 31)), $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 4);
      tick();
    end
    for (int c = 0; c < 20; c++) idle(1'b1);
    chk("drain_empty", {65'd0, empty_o}, 66'd1);

    // Reset with two results buffered and one still in the pipe.
    for (int c = 0; c < 7; c++) begin
      set_inputs(c < 3, 5'(c + 7), rand66(), 5'b01000, 1'b0, 1'b0);
      tick();
    end
    chk("pre_rst_wb_v", {65'd0, wb_v_o}, 66'd1);
    chk("pre_rst_empty", {65'd0, empty_o}, 66'd0);
    fma_issue_i = 1'b0; fma_v_i = 1'b0; wb_yumi_i = 1'b0; fflags_clear_i = 1'b0;
    reset_i = 1'b1;
    #1;
    chk("mid_rst_wb_v", {65'd0, wb_v_o}, 66'd0);
    chk("mid_rst_ready", {65'd0, issue_ready_o}, 66'd1);
    chk("mid_rst_empty", {65'd0, empty_o}, 66'd1);
    chk("mid_rst_fflags", {61'd0, fflags_o}, 66'd0);
    pipe_reset();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    for (int c = 0; c < 8; c++) idle(1'b1);
    chk("post_rst_empty", {65'd0, empty_o}, 66'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_be_fma_wb_buffer.md
Name: bp_be_fma_wb_buffer

Overview:
Writeback buffer directly downstream of the FP FMA pipeline. The FMA pipeline is fixed-latency and cannot stall, so this block captures every FMA result and holds it in a small FIFO. It drains the FIFO to the shared FP register-file write port, where the load pipe has priority.
It also issues credit-based issue permission to the dispatcher, so the pipe can never overrun the buffer. It accumulates sticky fflags for the fcsr.

Parameters:
dpath_width_p, 66, width of an FP register value (1 sp_not_dp bit + 65-bit recoded DP).
reg_addr_width_p, 5, FP register address width.
els_p, 4, FIFO depth; must be a power of 2 and >= 2.
fma_latency_p, 5, FMA pipe latency in cycles; used only for assertions.

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
fma_issue_i  in  1  dispatcher issued an FMA op this cycle; only legal when issue_ready_o=1
issue_ready_o  out  1  a credit is available for one more FMA issue
fma_v_i  in  1  FMA result valid from the pipe
fma_data_i  in  dpath_width_p  FMA result (bp_be_fp_reg_s)
fma_fflags_i  in  5  result exception flags (rv64_fflags_s)
fma_rd_i  in  reg_addr_width_p  destination register, carried alongside the pipe
wb_v_o  out  1  write request to the FP register file
wb_addr_o  out  reg_addr_width_p  write address
wb_data_o  out  dpath_width_p  write data
wb_yumi_i  in  1  port granted this cycle (load pipe not writing); only legal when wb_v_o=1
fflags_o  out  5  sticky accumulated fflags
fflags_clear_i  in  1  CSR write clears the accumulator
empty_o  out  1  FIFO empty and no results in flight; used for fence/interrupt drain

Behaviour:
- Reset (async): FIFO pointers = 0, occupancy = 0, in-flight count = 0, fflags_o = 0.
  Outputs after reset: wb_v_o = 0, issue_ready_o = 1, empty_o = 1.
- FIFO: els_p entries of {rd, data, fflags}, with read/write pointers of log2(els_p) bits that wrap naturally.
  - Enqueue on fma_v_i.
  - Dequeue on wb_yumi_i.
  - Enqueue and dequeue in the same cycle are legal at any occupancy, including full; occupancy is then unchanged.
- wb_v_o = FIFO non-empty. wb_addr_o and wb_data_o come from the head entry and are registered.
  Base latency: fma_v_i at cycle N gives wb_v_o at N+1 at the earliest.
- Credits:
  - inflight counter, width log2(els_p)+1: +1 on fma_issue_i, -1 on fma_v_i; both in one cycle leaves it unchanged.
  - credits = els_p - occupancy - inflight.
  - issue_ready_o = (credits != 0), computed from registered state only.
  - A dequeue frees a credit the next cycle.
- Error assertions:
  - fma_v_i while FIFO full without a simultaneous yumi.
  - fma_issue_i while issue_ready_o = 0.
  - wb_yumi_i while wb_v_o = 0.
  - inflight underflow.
  - inflight > fma_latency_p.
- fflags:
  - On each dequeue, fflags_o <= fflags_o | head.fflags.
  - fflags_clear_i has priority in the same cycle: fflags_o <= 0 and the dequeued flags are dropped.
  - Flags are accumulated at writeback, not at enqueue.
- empty_o = (occupancy == 0) && (inflight == 0).
- Reset mid-operation drops all buffered and in-flight results. The dispatcher is reset together with this block.

Optional Feature:
- Macro BP_BE_FMA_WB_BYPASS_EN. When defined and the FIFO is empty, fma_v_i is presented combinationally on wb_* in the same cycle (0-cycle latency).
  - If wb_yumi_i is asserted that cycle, the result is not enqueued, its fflags are accumulated, and its credit returns the next cycle.
  - If wb_yumi_i is not asserted, the result is enqueued as normal.
- When undefined: the registered path only, with 1-cycle minimum latency and no combinational path from fma_* to wb_*.

Decomposition:
- Package bp_be_pkg holds:
  - the entry typedef bp_be_fma_wb_entry_s {rd, bp_be_fp_reg_s data, rv64_fflags_s fflags};
  - the rv64_fflags_s width constant.
- Sub-module: the FIFO is a natural split, bp_be_fma_wb_fifo (storage, pointers, occupancy, full/empty).
- Credit counting, bypass and fflags accumulation stay in the top module.

Test Plan:
- Reset mid-stream: 2 results buffered plus 1 in flight, then assert reset_i -> all outputs immediately at reset values and fflags_o = 0.
- Single op: issue at cycle 0, fma_v_i at cycle 5 with rd=3, data=0x1_0000_0000_0000_0001, fflags=5'b00001, yumi held at 1 -> wb_v_o at cycle 6 with rd 3, fflags_o = 5'b00001 at cycle 7, empty_o = 1 at cycle 7.
- Credit exhaustion: els_p=4, 4 back-to-back issues, yumi held at 0 -> issue_ready_o = 0 from cycle 4; single yumi after 4 results arrive -> issue_ready_o = 1 the next cycle.
- Full FIFO with simultaneous enqueue and yumi -> occupancy stays 4, order preserved (rd 1,2,3,4,5 written in order), no assertion fires.
- Port contention: yumi low for 3 cycles while 3 results arrive -> wb_data_o stable and equal to the head; drains in order once yumi rises.
- fflags: dequeue with flags 5'b10000 in the same cycle as fflags_clear_i -> fflags_o = 0.
  With BP_BE_FMA_WB_BYPASS_EN on an empty FIFO: fma_v_i with yumi -> wb_v_o in the same cycle, occupancy remains 0.
